// File: rtl/delay_line_ctrl_pkg.sv
// Shared DSP definitions: default datapath widths and the delay-line FSM encoding.
package delay_line_ctrl_pkg;

  localparam int unsigned DSP_DATA_WIDTH = 16;
  localparam int unsigned DSP_ADDR_WIDTH = 13;

  typedef logic [2:0] dl_state_t;

  localparam dl_state_t IDLE     = 3'd0;
  localparam dl_state_t RD_ISSUE = 3'd1;
  localparam dl_state_t RD_WAIT  = 3'd2;
  localparam dl_state_t WR_ISSUE = 3'd3;
  localparam dl_state_t WR_HOLD  = 3'd4;
  localparam dl_state_t OUT      = 3'd5;

endpackage

// File: rtl/delay_line_ctrl_addr_gen.sv
// Wrapped read-address generator for the circular delay buffer. Works for any
// line length, not only powers of two.
module delay_addr_gen #(
  parameter int unsigned addr_width = 13,
  parameter int unsigned base_addr  = 0,
  parameter int unsigned line_len   = 4096
) (
  input  logic [addr_width-1:0] wp,
  input  logic [addr_width-1:0] delay,
  output logic [addr_width-1:0] rd_addr
);

  // One extra bit so wp + line_len cannot overflow when line_len == 2^addr_width.
  localparam logic [addr_width:0]   len_ext = (addr_width+1)'(line_len);
  localparam logic [addr_width-1:0] base_w  = addr_width'(base_addr);

  logic [addr_width:0] wp_ext;
  logic [addr_width:0] d_ext;
  logic [addr_width:0] offset;

  // Offset = (wp - delay) mod line_len, borrowing one line length on underflow.
  always_comb begin
    wp_ext = {1'b0, wp};
    d_ext  = {1'b0, delay};
    if (wp_ext >= d_ext) begin
      offset = wp_ext - d_ext;
    end else begin
      offset = wp_ext + len_ext - d_ext;
    end
    rd_addr = base_w + offset[addr_width-1:0];
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Sample delay line backed by an external single-word SRAM. Each accepted sample
// reads the word written `delay` samples ago, writes the new sample at the write
// pointer, then strobes the delayed sample out.
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int unsigned data_width = DSP_DATA_WIDTH,
  parameter int unsigned addr_width = DSP_ADDR_WIDTH,
  parameter int unsigned base_addr  = 0,
  parameter int unsigned line_len   = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] in_sample,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [addr_width-1:0] delay,
  input  logic                  clear,
  output logic [data_width-1:0] out_sample,
  output logic                  out_valid,
  output logic                  error,
  input  logic                  error_clr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [addr_width-1:0] mem_read_addr,
  output logic [addr_width-1:0] mem_write_addr,
  output logic [data_width-1:0] mem_data_in,
  input  logic [data_width-1:0] mem_data_out,
  input  logic                  mem_read_ready,
  input  logic                  mem_write_ready,
  input  logic                  mem_invalid_read,
  input  logic                  mem_invalid_write
);

  localparam logic [addr_width-1:0] max_delay = addr_width'(line_len - 1);
  localparam logic [addr_width-1:0] base_w    = addr_width'(base_addr);

  dl_state_t             state;
  logic [addr_width-1:0] wp;
  logic [data_width-1:0] sample_q;
  logic [addr_width-1:0] rd_addr_q;
  logic [addr_width-1:0] wr_addr_q;
  logic                  mem_read_q;
  logic [data_width-1:0] out_sample_q;
  logic                  error_q;

  logic [addr_width-1:0] delay_clamped;
  logic [addr_width-1:0] rd_addr_next;
  logic                  accept;

  // Clamp requested delay so the read never reaches past the oldest stored word.
  always_comb begin
    delay_clamped = (delay > max_delay) ? max_delay : delay;
  end

  delay_addr_gen #(
    .addr_width (addr_width),
    .base_addr  (base_addr),
    .line_len   (line_len)
  ) u_addr_gen (
    .wp      (wp),
    .delay   (delay_clamped),
    .rd_addr (rd_addr_next)
  );

  // Handshake and SRAM strobes decoded from the current state.
  always_comb begin
    in_ready       = (state == IDLE) && !clear;
    accept         = in_valid && in_ready;
    out_valid      = (state == OUT);
    mem_write      = ((state == WR_ISSUE) && mem_write_ready) || (state == WR_HOLD);
    mem_read       = mem_read_q;
    mem_read_addr  = rd_addr_q;
    mem_write_addr = wr_addr_q;
    mem_data_in    = sample_q;
    out_sample     = out_sample_q;
    error          = error_q;
  end

  // Main FSM with the latched transaction context and write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wp           <= '0;
      sample_q     <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      mem_read_q   <= 1'b0;
      out_sample_q <= '0;
    end else begin
      mem_read_q <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            wp <= '0;
          end else if (accept) begin
            sample_q  <= in_sample;
            rd_addr_q <= rd_addr_next;
            wr_addr_q <= base_w + wp;
            if (delay_clamped == '0) begin
              out_sample_q <= in_sample;
              state        <= WR_ISSUE;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          if (mem_read_ready) begin
            mem_read_q <= 1'b1;
            state      <= RD_WAIT;
          end
        end
        // The read strobe is registered, so data is only taken once it has retired.
        RD_WAIT: begin
          if (mem_read_ready && !mem_read_q) begin
            out_sample_q <= mem_data_out;
            state        <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (mem_write_ready) begin
            state <= WR_HOLD;
          end
        end
        WR_HOLD: state <= OUT;
        OUT: begin
          wp    <= (wp == max_delay) ? '0 : wp + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky fault flag; a new fault wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= (error_q && !error_clr) || mem_invalid_read || mem_invalid_write;
    end
  end

endmodule
